md_sequencer: RTL and testbench



---
 rtl/md_sequencer_if.sv | 24 ++
 rtl/md_sequencer.sv | 159 +++++++++++++++
 tb/tb_md_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/md_sequencer_if.sv
// EX-stage <-> M-extension sequencer handshake: op request, flush, stall and result return.
interface md_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            flush;
  logic            busy;
  logic            stall_req;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, rs1_val, rs2_val, flush,
    input  busy, stall_req, done, result
  );

  modport slave (
    input  start, funct3, rs1_val, rs2_val, flush,
    output busy, stall_req, done, result
  );
endinterface

// File: rtl/md_sequencer.sv
// Iterative RV32M multiply/divide sequencer: one shift-add / restoring-subtract step per cycle.
// Optional macro MD_EARLY_OUT_EN: finish divide-by-zero, signed overflow and zero-operand multiply in one cycle.
module md_sequencer #(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  md_sequencer_if.slave    bus
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        funct3_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CW-1:0]     count_q;
  logic              neg_a_q, neg_b_q, div0_q, ovf_q;
  logic [XLEN-1:0]   result_q;

  // Operand decode on the incoming op
  logic            in_is_div, in_sa_en, in_sb_en, in_sa, in_sb;
  logic            in_div0, in_ovf, accept, early;
  logic [XLEN-1:0] in_mag_a, in_mag_b, early_res;

  assign in_is_div = bus.funct3[2];
  assign in_sa_en  = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                     (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
  assign in_sb_en  = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) ||
                     (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
  assign in_sa     = in_sa_en && bus.rs1_val[XLEN-1];
  assign in_sb     = in_sb_en && bus.rs2_val[XLEN-1];
  assign in_mag_a  = in_sa ? (~bus.rs1_val + 1'b1) : bus.rs1_val;
  assign in_mag_b  = in_sb ? (~bus.rs2_val + 1'b1) : bus.rs2_val;
  assign in_div0   = in_is_div && (bus.rs2_val == '0);
  assign in_ovf    = in_is_div && !bus.funct3[0] && (bus.rs1_val == MIN_NEG) && (bus.rs2_val == '1);
  assign accept    = (state_q == S_IDLE) && bus.start && !bus.flush;

`ifdef MD_EARLY_OUT_EN
  logic in_mul0;
  assign in_mul0 = !in_is_div && ((bus.rs1_val == '0) || (bus.rs2_val == '0));
  assign early   = in_div0 || in_ovf || in_mul0;
  always_comb begin
    early_res = '0;
    if (in_div0)
      early_res = bus.funct3[1] ? bus.rs1_val : '1;
    else if (in_ovf)
      early_res = bus.funct3[1] ? '0 : MIN_NEG;
  end
`else
  assign early     = 1'b0;
  assign early_res = '0;
`endif

  // One iteration of each datapath
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] mul_acc;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;

  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (b_q[0] ? {1'b0, a_q} : '0);
  assign mul_acc   = {mul_sum, acc_q[XLEN-1:1]};
  assign div_shift = {acc_q[XLEN-1:0], a_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_ge    = (div_shift >= {1'b0, b_q});
  assign div_rem   = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];

  // Sign correction; divide special cases are forced independent of the magnitude path
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_res;

  assign prod = (neg_a_q ^ neg_b_q) ? (~acc_q + 1'b1) : acc_q;
  assign quo  = (neg_a_q ^ neg_b_q) ? (~a_q + 1'b1) : a_q;
  assign rem  = neg_a_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];

  always_comb begin
    fix_res = '0;
    case (funct3_q)
      3'b000:                 fix_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = div0_q ? '1 : (ovf_q ? MIN_NEG : quo);
      default:                fix_res = ovf_q ? '0 : rem;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    bus.stall_req = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        bus.stall_req = 1'b1;
        state_d       = early ? S_DONE : S_RUN;
      end
      S_RUN: begin
        bus.stall_req = 1'b1;
        if (count_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        bus.stall_req = 1'b1;
        state_d       = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          funct3_q <= bus.funct3;
          a_q      <= in_mag_a;
          b_q      <= in_mag_b;
          neg_a_q  <= in_sa;
          neg_b_q  <= in_sb;
          div0_q   <= in_div0;
          ovf_q    <= in_ovf;
          acc_q    <= '0;
          count_q  <= CW'(XLEN);
          if (early) result_q <= early_res;
        end
        S_RUN: begin
          count_q <= count_q - 1'b1;
          if (funct3_q[2]) begin
            a_q   <= {a_q[XLEN-2:0], div_ge};
            acc_q <= {{XLEN{1'b0}}, div_rem};
          end else begin
            b_q   <= b_q >> 1;
            acc_q <= mul_acc;
          end
        end
        S_FIX: if (!bus.flush) result_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;
endmodule

// File: tb/tb_md_sequencer.sv
// Randomized self-checking bench for md_sequencer against an arithmetic RV32M reference model.
module tb_md_sequencer;
  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  md_sequencer_if #(.XLEN(32)) bus ();

  md_sequencer #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    longint      ps;
    logic [63:0] pu;
    sa = int'(a);
    sb = int'(b);
    case (f)
      3'b000: begin ps = longint'(sa) * longint'(sb); return ps[31:0]; end
      3'b001: begin ps = longint'(sa) * longint'(sb); return ps[63:32]; end
      3'b010: begin ps = longint'(sa) * longint'({32'b0, b}); return ps[63:32]; end
      3'b011: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MD_EARLY_OUT_EN
    logic special;
    if (f[2]) special = (b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    else      special = (a == 0) || (b == 0);
    if (special) return 1;
`endif
    return 34;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int          lat;
    int          done_cycle;
    int          done_cnt;
    int          stall_cnt;
    int          busy_cnt;
    logic [31:0] res_at_done;
    logic [31:0] exp_res;
    lat        = exp_latency(f, a, b);
    exp_res    = ref_md(f, a, b);
    done_cycle = -1;
    done_cnt   = 0;
    stall_cnt  = 0;
    busy_cnt   = 0;
    res_at_done = '0;
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.funct3  = f;
    bus.rs1_val = a;
    bus.rs2_val = b;
    for (int k = 0; k <= lat + 2; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.stall_req) stall_cnt++;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_cycle < 0) begin
          done_cycle  = k;
          res_at_done = bus.result;
        end
      end
    end
    $display("[TB] %s f=%0d a=%08h b=%08h -> result %08h at cycle %0d (want %08h at %0d)",
             tag, f, a, b, res_at_done, done_cycle, exp_res, lat);
    check({tag, ".done_cycle"}, 64'(done_cycle), 64'(lat));
    check({tag, ".done_cnt"},   64'(done_cnt),   64'd1);
    check({tag, ".result"},     64'(res_at_done), 64'(exp_res));
    check({tag, ".stall_cnt"},  64'(stall_cnt),  64'(lat));
    check({tag, ".busy_cnt"},   64'(busy_cnt),   64'(lat));
    check({tag, ".held"},       64'(bus.result), 64'(exp_res));
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'(($urandom_range(0, 15)));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [31:0] prev;
    int          done_seen;
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.flush    = 1'b0;
    bus.funct3   = '0;
    bus.rs1_val  = '0;
    bus.rs2_val  = '0;
    repeat (3) @(negedge clk);
    check("rst.busy",   64'(bus.busy),      64'd0);
    check("rst.done",   64'(bus.done),      64'd0);
    check("rst.result", 64'(bus.result),    64'd0);
    check("rst.stall",  64'(bus.stall_req), 64'd0);
    rst_n = 1'b1;

    run_op("mul",    3'b000, 32'd7,          32'hFFFF_FFFD);
    run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'h0000_0002);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2);
    run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2);
    run_op("divu",   3'b101, 32'd100,        32'd7);
    run_op("remu",   3'b111, 32'd100,        32'd7);
    run_op("divu0",  3'b101, 32'd5,          32'd0);
    run_op("remu0",  3'b111, 32'd5,          32'd0);
    run_op("div0s",  3'b100, 32'hFFFF_FFF0, 32'd0);
    run_op("rem0s",  3'b110, 32'hFFFF_FFF0, 32'd0);
    run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mulz",   3'b001, 32'h0,          32'h1234_5678);

    // Flush mid-divide
    prev      = bus.result;
    done_seen = 0;
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.funct3  = 3'b100;
    bus.rs1_val = 32'd1000;
    bus.rs2_val = 32'd3;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (bus.done) done_seen++;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.flush = (k == 10);
    end
    @(negedge clk);
    if (bus.done) done_seen++;
    check("flush.busy",   64'(bus.busy),   64'd0);
    check("flush.done",   64'(done_seen),  64'd0);
    check("flush.result", 64'(bus.result), 64'(prev));
    run_op("after_flush", 3'b100, 32'd1000, 32'd3);

    // start and flush together in IDLE
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.flush   = 1'b1;
    bus.funct3  = 3'b000;
    bus.rs1_val = 32'd3;
    bus.rs2_val = 32'd4;
    @(negedge clk);
    check("sf.stall", 64'(bus.stall_req), 64'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    check("sf.busy", 64'(bus.busy), 64'd0);

    // Asynchronous reset mid-multiply
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.funct3  = 3'b000;
    bus.rs1_val = 32'd11;
    bus.rs2_val = 32'd13;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.busy",   64'(bus.busy),   64'd0);
    check("arst.done",   64'(bus.done),   64'd0);
    check("arst.result", 64'(bus.result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", 3'b000, 32'd11, 32'd13);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      run_op($sformatf("rnd%0d", i), f, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
